// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle HACK CPU core.
//   state_t     : control FSM states
//   BIT_*/C_*/D*/J* : instruction field bit positions
//   J*          : jump-condition codes (j2 j1 j0)
//   jump_taken(): condition evaluation from ALU flags
package hack_pkg;

    typedef enum logic [2:0] {
        FETCH,
        MEMRD,
        EXEC,
        MEMWR,
        HALT
    } state_t;

    localparam int unsigned BIT_CI = 15;
    localparam int unsigned BIT_A  = 12;
    localparam int unsigned C_HI   = 11;
    localparam int unsigned C_LO   = 6;
    localparam int unsigned D1     = 5;
    localparam int unsigned D2     = 4;
    localparam int unsigned D3     = 3;
    localparam int unsigned J2     = 2;
    localparam int unsigned J1     = 1;
    localparam int unsigned J0     = 0;

    localparam logic [2:0] JNULL = 3'b000;
    localparam logic [2:0] JGT   = 3'b001;
    localparam logic [2:0] JEQ   = 3'b010;
    localparam logic [2:0] JGE   = 3'b011;
    localparam logic [2:0] JLT   = 3'b100;
    localparam logic [2:0] JNE   = 3'b101;
    localparam logic [2:0] JLE   = 3'b110;
    localparam logic [2:0] JMP   = 3'b111;

    // j2 = less-than, j1 = equal, j0 = greater-than
    function automatic logic jump_taken(input logic [2:0] j, input logic zr, input logic ng);
        return (j[J2] & ng) | (j[J1] & zr) | (j[J0] & ~ng & ~zr);
    endfunction

endpackage

// File: rtl/hack_alu.sv
// HACK ALU, combinational, DATA_W wide.
//   x, y : operands (x = D, y = A or M)
//   c    : {zx, nx, zy, ny, f, no}
//   out  : result; zr = (out == 0); ng = out MSB
module hack_alu #(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] x,
    input  logic [DATA_W-1:0] y,
    input  logic [5:0]        c,
    output logic [DATA_W-1:0] out,
    output logic              zr,
    output logic              ng
);

    logic [DATA_W-1:0] x_z;
    logic [DATA_W-1:0] x_n;
    logic [DATA_W-1:0] y_z;
    logic [DATA_W-1:0] y_n;
    logic [DATA_W-1:0] f_out;

    always_comb begin
        x_z   = c[5] ? '0 : x;
        x_n   = c[4] ? ~x_z : x_z;
        y_z   = c[3] ? '0 : y;
        y_n   = c[2] ? ~y_z : y_z;
        f_out = c[1] ? (x_n + y_n) : (x_n & y_n);
        out   = c[0] ? ~f_out : f_out;
        zr    = (out == '0);
        ng    = out[DATA_W-1];
    end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle HACK CPU core with req/ack handshakes to instruction and data memories.
// Ports:
//   clk, reset (async, active-low)
//   imem_req/imem_addr/imem_rdata/imem_ack            : instruction fetch bus
//   dmem_req/dmem_we/dmem_addr/dmem_wdata/dmem_rdata/dmem_ack : data bus
//   pc_out, a_reg, d_reg                              : debug views of PC/A/D
//   halted                                            : sticky jump-to-self detect
// Optional build macro HACK_CPU_PERF_EN adds retired_cnt[31:0] and stall_cnt[31:0].
module hack_cpu_mc
    import hack_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_ack,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [ADDR_W-1:0] pc_out,
    output logic [DATA_W-1:0] a_reg,
    output logic [DATA_W-1:0] d_reg,
    output logic              halted
`ifdef HACK_CPU_PERF_EN
    ,
    output logic [31:0]       retired_cnt,
    output logic [31:0]       stall_cnt
`endif
);

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [15:0]       ir;
    logic [DATA_W-1:0] m_lat;
    logic [DATA_W-1:0] res_lat;
    logic [ADDR_W-1:0] wr_addr;

    logic [DATA_W-1:0] alu_y;
    logic [DATA_W-1:0] alu_out;
    logic              alu_zr;
    logic              alu_ng;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] pc_inc;
    logic              taken;
    logic              halt_set;

    hack_alu #(
        .DATA_W(DATA_W)
    ) u_alu (
        .x  (d_reg),
        .y  (alu_y),
        .c  (ir[C_HI:C_LO]),
        .out(alu_out),
        .zr (alu_zr),
        .ng (alu_ng)
    );

    always_comb begin
        alu_y    = ir[BIT_A] ? m_lat : a_reg;
        a_addr   = a_reg[ADDR_W-1:0];
        pc_inc   = pc + ADDR_W'(1);
        taken    = ir[BIT_CI] & jump_taken(ir[J2:J0], alu_zr, alu_ng);
        halt_set = taken && (a_addr == pc);
    end

    // Requests are decoded from the state but forced low while reset is held,
    // so a transfer in flight is dropped the moment reset asserts.
    always_comb begin
        imem_req   = reset && (state == FETCH);
        dmem_req   = reset && ((state == MEMRD) || (state == MEMWR));
        dmem_we    = reset && (state == MEMWR);
        imem_addr  = pc;
        dmem_addr  = (state == MEMWR) ? wr_addr : a_addr;
        dmem_wdata = res_lat;
        pc_out     = pc;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= '0;
            a_reg   <= '0;
            d_reg   <= '0;
            ir      <= '0;
            m_lat   <= '0;
            res_lat <= '0;
            wr_addr <= '0;
            halted  <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (imem_ack) begin
                        ir    <= imem_rdata;
                        state <= (imem_rdata[BIT_CI] && imem_rdata[BIT_A]) ? MEMRD : EXEC;
                    end
                end
                MEMRD: begin
                    if (dmem_ack) begin
                        m_lat <= dmem_rdata;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    if (!ir[BIT_CI]) begin
                        a_reg <= DATA_W'(ir[14:0]);
                        pc    <= pc_inc;
                        state <= FETCH;
                    end else begin
                        if (ir[D1]) a_reg <= alu_out;
                        if (ir[D2]) d_reg <= alu_out;
                        // Write address is the A value before this instruction updates it.
                        if (ir[D3]) begin
                            res_lat <= alu_out;
                            wr_addr <= a_addr;
                        end
                        pc <= taken ? a_addr : pc_inc;
                        if (halt_set) halted <= 1'b1;
                        if (ir[D3])        state <= MEMWR;
                        else if (halt_set) state <= HALT;
                        else               state <= FETCH;
                    end
                end
                MEMWR: begin
                    if (dmem_ack) state <= halted ? HALT : FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef HACK_CPU_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired_cnt <= '0;
            stall_cnt   <= '0;
        end else if (state != HALT) begin
            if (state == EXEC) retired_cnt <= retired_cnt + 32'd1;
            if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hack_cpu_mc.sv
module tb_hack_cpu_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [14:0] imem_addr;
    logic [15:0] imem_rdata = '0;
    logic        imem_ack = 1'b0;
    logic        dmem_req;
    logic        dmem_we;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata = '0;
    logic        dmem_ack = 1'b0;
    logic [14:0] pc_out;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        halted;

    // 32-bit instance with zero-wait combinational responders
    logic        rst32 = 1'b0;
    logic        imem_req32;
    logic [14:0] imem_addr32;
    logic [15:0] imem_rdata32;
    logic        imem_ack32;
    logic        dmem_req32;
    logic        dmem_we32;
    logic [14:0] dmem_addr32;
    logic [31:0] dmem_wdata32;
    logic [31:0] dmem_rdata32;
    logic        dmem_ack32;
    logic [14:0] pc32;
    logic [31:0] a32;
    logic [31:0] d32;
    logic        halted32;

    always #5 clk = ~clk;

    hack_cpu_mc dut (
        .clk       (clk),
        .reset     (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ack  (imem_ack),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_addr (dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ack  (dmem_ack),
        .pc_out    (pc_out),
        .a_reg     (a_reg),
        .d_reg     (d_reg),
        .halted    (halted)
    );

    hack_cpu_mc #(
        .DATA_W(32),
        .ADDR_W(15)
    ) dut32 (
        .clk       (clk),
        .reset     (rst32),
        .imem_req  (imem_req32),
        .imem_addr (imem_addr32),
        .imem_rdata(imem_rdata32),
        .imem_ack  (imem_ack32),
        .dmem_req  (dmem_req32),
        .dmem_we   (dmem_we32),
        .dmem_addr (dmem_addr32),
        .dmem_wdata(dmem_wdata32),
        .dmem_rdata(dmem_rdata32),
        .dmem_ack  (dmem_ack32),
        .pc_out    (pc32),
        .a_reg     (a32),
        .d_reg     (d32),
        .halted    (halted32)
    );

    logic [15:0] imem32 [8];
    logic [31:0] dmem32 [8];
    assign imem_ack32   = imem_req32;
    assign imem_rdata32 = imem32[imem_addr32[2:0]];
    assign dmem_ack32   = dmem_req32;
    assign dmem_rdata32 = dmem32[dmem_addr32[2:0]];
    always @(posedge clk) if (dmem_req32 && dmem_we32) dmem32[dmem_addr32[2:0]] <= dmem_wdata32;

    // Instruction encodings
    localparam logic [15:0] I_D_EQ_A   = 16'hEC10;
    localparam logic [15:0] I_D_DPA    = 16'hE090;
    localparam logic [15:0] I_M_EQ_D   = 16'hE308;
    localparam logic [15:0] I_AM_MP1   = 16'hFDE8;
    localparam logic [15:0] I_M_MP1JEQ = 16'hFDCA;
    localparam logic [15:0] I_ZJMP     = 16'hEA87;
    localparam logic [15:0] I_D_M1     = 16'hEE90;
    localparam logic [15:0] I_D_0      = 16'hEA90;
    localparam logic [15:0] I_D_1      = 16'hEFD0;
    localparam logic [15:0] I_DJLT     = 16'hE304;
    localparam logic [15:0] I_DJEQ     = 16'hE302;
    localparam logic [15:0] I_DJGT     = 16'hE301;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
        logic [15:0] a_exp;
        int          cyc_exp;  // 0 = cycle not checked
    } wr_t;

    typedef struct {
        logic [15:0] dinst;
        logic [15:0] jinst;
        logic [14:0] pc_exp;
        logic [15:0] d_exp;
    } vec_t;

    wr_t         exp_q[$];
    logic [15:0] imem [64];
    logic [15:0] dmem [128];
    int          tests = 0;
    int          fails = 0;
    int          max_wait = 0;
    int          cyc;
    int          i_cnt = 0;
    int          d_cnt = 0;
    logic        i_pend = 1'b0;
    logic        d_pend = 1'b0;
    logic [14:0] i_paddr;
    logic [31:0] d_pinfo;
    logic [15:0] d_pdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    // Memory responder with random wait states, hold checker and write scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            i_cnt    = 0;
            d_cnt    = 0;
            i_pend   = 1'b0;
            d_pend   = 1'b0;
        end else begin
            if (i_pend) check("imem_hold", {imem_req, imem_addr}, {1'b1, i_paddr});
            if (d_pend) check("dmem_hold", {dmem_req, dmem_we, dmem_addr, dmem_wdata},
                              {1'b1, d_pinfo[15:0], d_pdata});
            if (imem_ack) i_cnt = $urandom_range(max_wait, 0);
            if (dmem_ack) d_cnt = $urandom_range(max_wait, 0);
            if (imem_req && i_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = imem[imem_addr[5:0]];
            end else begin
                imem_ack = 1'b0;
                if (imem_req) i_cnt--;
            end
            if (dmem_req && d_cnt == 0) begin
                dmem_ack = 1'b1;
                if (!dmem_we) dmem_rdata = dmem[dmem_addr[6:0]];
            end else begin
                dmem_ack = 1'b0;
                if (dmem_req) d_cnt--;
            end
            if (dmem_req && dmem_we && dmem_ack) begin
                if (exp_q.size() == 0) begin
                    check("write_expected", 64'(exp_q.size()), 64'd1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_addr", dmem_addr, e.addr);
                    check("wr_data", dmem_wdata, e.data);
                    check("wr_a_after", a_reg, e.a_exp);
                    if (e.cyc_exp != 0) check("wr_cycle", 64'(cyc + 1), 64'(e.cyc_exp));
                end
                dmem[dmem_addr[6:0]] = dmem_wdata;
            end
            i_pend  = imem_req && !imem_ack;
            i_paddr = imem_addr;
            d_pend  = dmem_req && !dmem_ack;
            d_pinfo = {16'd0, dmem_we, dmem_addr};
            d_pdata = dmem_wdata;
        end
    end

    task automatic clear_imem();
        for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
    endtask

    task automatic load_prog2();
        clear_imem();
        imem[0] = 16'd5;
        imem[1] = I_D_EQ_A;
        imem[2] = 16'd7;
        imem[3] = I_D_DPA;
        imem[4] = 16'd0;
        imem[5] = I_M_EQ_D;
        imem[6] = 16'd7;
        imem[7] = I_ZJMP;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_halt(input string name, input int bound);
        int n = 0;
        while (!halted && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, halted, 1'b1);
    endtask

    task automatic count_idle_fetch(input string name);
        int reqs = 0;
        repeat (10) begin
            @(negedge clk);
            if (imem_req) reqs++;
        end
        check(name, 64'(reqs), 64'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{I_D_M1, I_DJLT, 15'd21, 16'hFFFF};
        vecs[1] = '{I_D_M1, I_DJEQ, 15'd12, 16'hFFFF};
        vecs[2] = '{I_D_M1, I_DJGT, 15'd12, 16'hFFFF};
        vecs[3] = '{I_D_0,  I_DJEQ, 15'd21, 16'h0000};
        vecs[4] = '{I_D_1,  I_DJGT, 15'd21, 16'h0001};
        vecs[5] = '{I_D_0,  I_DJLT, 15'd12, 16'h0000};
        for (int i = 0; i < 128; i++) dmem[i] = 16'h0000;

        // Async reset in the middle of a program, then a full run with wait states
        load_prog2();
        max_wait = 3;
        do_reset();
        begin
            int n = 0;
            while (!(pc_out == 15'd4 && imem_req) && n < 300) begin
                @(negedge clk);
                n++;
            end
        end
        check("reach_pc4", pc_out, 15'd4);
        check("a_before_reset", a_reg, 16'd7);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_dmem_req", {dmem_req, dmem_we}, 2'b00);
        check("rst_pc", pc_out, 15'd0);
        check("rst_a_d", {a_reg, d_reg}, 32'd0);
        check("rst_buses", {imem_addr, dmem_addr, dmem_wdata, halted}, 47'd0);
        repeat (2) @(posedge clk);
        exp_q.push_back('{15'd0, 16'd12, 16'd0, 0});
        #1 rst = 1'b1;
        #1;
        check("release_fetch", {imem_req, imem_addr}, {1'b1, 15'd0});
        wait_halt("halt_prog_wait1", 400);
        check("prog_wait1_ad", {a_reg, d_reg}, {16'd7, 16'd12});
        check("prog_wait1_q", 64'(exp_q.size()), 64'd0);

        // Zero-wait program with exact cycle count
        dmem[0] = 16'h0000;
        max_wait = 0;
        exp_q.push_back('{15'd0, 16'd12, 16'd0, 13});
        do_reset();
        wait_halt("halt_prog0", 200);
        check("prog0_pc", pc_out, 15'd7);
        check("prog0_ad", {a_reg, d_reg}, {16'd7, 16'd12});
        check("prog0_mem", dmem[0], 16'd12);
        check("prog0_q", 64'(exp_q.size()), 64'd0);
        count_idle_fetch("prog0_no_fetch_after_halt");

        // Same program, random wait states
        dmem[0] = 16'h0000;
        max_wait = 3;
        exp_q.push_back('{15'd0, 16'd12, 16'd0, 0});
        do_reset();
        wait_halt("halt_prog_wait2", 400);
        check("prog_wait2_pc", pc_out, 15'd7);
        check("prog_wait2_ad", {a_reg, d_reg}, {16'd7, 16'd12});
        check("prog_wait2_mem", dmem[0], 16'd12);
        check("prog_wait2_q", 64'(exp_q.size()), 64'd0);

        // Conditional jumps at PC=10 with A=20
        max_wait = 0;
        for (int v = 0; v < 6; v++) begin
            clear_imem();
            imem[0] = vecs[v].dinst;
            for (int k = 1; k < 10; k++) imem[k] = 16'd20;
            imem[10] = vecs[v].jinst;
            imem[11] = 16'd12;
            imem[12] = I_ZJMP;
            imem[20] = 16'd21;
            imem[21] = I_ZJMP;
            do_reset();
            wait_halt($sformatf("jump%0d_halt", v), 200);
            check($sformatf("jump%0d_pc", v), pc_out, vecs[v].pc_exp);
            check($sformatf("jump%0d_d", v), d_reg, vecs[v].d_exp);
        end

        // Jump-to-self halt, then reset clears it
        clear_imem();
        imem[2] = 16'd3;
        imem[3] = I_ZJMP;
        do_reset();
        wait_halt("self_halt", 100);
        check("self_halt_pc_a", {pc_out, a_reg}, {15'd3, 16'd3});
        count_idle_fetch("self_halt_no_fetch");
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check("reset_clears_halt", halted, 1'b0);
        #1 rst = 1'b1;

        // AM=M+1: read-modify-write with old A as the write address
        clear_imem();
        imem[0] = 16'd100;
        imem[1] = I_AM_MP1;
        imem[2] = 16'd3;
        imem[3] = I_ZJMP;
        dmem[100] = 16'd41;
        exp_q.push_back('{15'd100, 16'd42, 16'd42, 6});
        do_reset();
        wait_halt("am_halt", 200);
        check("am_mem", dmem[100], 16'd42);
        check("am_q", 64'(exp_q.size()), 64'd0);

        // 32-bit datapath: 0xFFFFFFFF + 1 wraps to 0 and sets zr (jump taken)
        for (int i = 0; i < 8; i++) begin
            imem32[i] = 16'h0000;
            dmem32[i] = 32'h0;
        end
        imem32[0] = 16'd5;
        imem32[1] = I_M_MP1JEQ;
        imem32[2] = 16'd3;
        imem32[3] = I_ZJMP;
        imem32[5] = 16'd6;
        imem32[6] = I_ZJMP;
        dmem32[5] = 32'hFFFF_FFFF;
        @(posedge clk);
        #1 rst32 = 1'b1;
        begin
            int n = 0;
            while (!halted32 && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        check("w32_halt", halted32, 1'b1);
        check("w32_pc", pc32, 15'd6);
        check("w32_mem", dmem32[5], 32'h0);
        check("w32_ad", {a32, d32}, {32'd6, 32'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
